// File: rtl/pe_operand_join_pkg.sv
// Shared defaults and sizing helper for the operand-join block and its lane buffers.
package pe_operand_join_pkg;

  localparam int unsigned DEFAULT_WIDTH_A = 16;
  localparam int unsigned DEFAULT_WIDTH_B = 32;
  localparam int unsigned DEFAULT_DEPTH   = 4;

  // Occupancy counters need one extra bit so that "full" (== depth) is representable.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pe_operand_join_lane.sv
// Single-lane circular buffer with a registered head entry and an occupancy count.
module pe_lane_fifo
  import pe_operand_join_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH_A,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_valid,
  output logic                            push_ready,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  output logic [WIDTH-1:0]                head,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Ready is held high through reset; anything offered then is discarded below.
  assign push_ready = rst || (count < FULL);
  assign do_push    = push_valid && push_ready && !rst;
  assign do_pop     = pop && (count != '0) && !rst;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_operand_join.sv
// Joins two independent operand streams into FIFO-ordered (A, B) pairs for a PE.
module pe_operand_join
  import pe_operand_join_pkg::*;
#(
  parameter int unsigned WIDTH_A = DEFAULT_WIDTH_A,
  parameter int unsigned WIDTH_B = DEFAULT_WIDTH_B,
  parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in0_valid,
  output logic                          in0_ready,
  input  logic [WIDTH_A-1:0]            in0_data,
  input  logic                          in1_valid,
  output logic                          in1_ready,
  input  logic [WIDTH_B-1:0]            in1_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH_A-1:0]            out_a_data,
  output logic [WIDTH_B-1:0]            out_b_data,
  output logic [count_width(DEPTH)-1:0] count_a,
  output logic [count_width(DEPTH)-1:0] count_b
);

  logic fire;

  // A pair exists only when both lanes hold an entry; a fire drains one from each.
  assign out_valid = (count_a != '0) && (count_b != '0);
  assign fire      = out_valid && out_ready;

  pe_lane_fifo #(
    .WIDTH (WIDTH_A),
    .DEPTH (DEPTH)
  ) u_lane_a (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in0_valid),
    .push_ready (in0_ready),
    .push_data  (in0_data),
    .pop        (fire),
    .head       (out_a_data),
    .count      (count_a)
  );

  pe_lane_fifo #(
    .WIDTH (WIDTH_B),
    .DEPTH (DEPTH)
  ) u_lane_b (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in1_valid),
    .push_ready (in1_ready),
    .push_data  (in1_data),
    .pop        (fire),
    .head       (out_b_data),
    .count      (count_b)
  );

endmodule

// File: tb/tb_pe_operand_join.sv
// Self-checking bench for pe_operand_join against a queue-based pairing model.
module tb_pe_operand_join;

  localparam int unsigned WA = 16;
  localparam int unsigned WB = 32;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in0_valid;
  logic          in0_ready;
  logic [WA-1:0] in0_data;
  logic          in1_valid;
  logic          in1_ready;
  logic [WB-1:0] in1_data;
  logic          out_valid;
  logic          out_ready;
  logic [WA-1:0] out_a_data;
  logic [WB-1:0] out_b_data;
  logic [2:0]    count_a;
  logic [2:0]    count_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [WA-1:0] qa[$];
  logic [WB-1:0] qb[$];

  always #5 clk = ~clk;

  pe_operand_join #(
    .WIDTH_A (WA),
    .WIDTH_B (WB),
    .DEPTH   (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in0_data   (in0_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in1_data   (in1_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a_data (out_a_data),
    .out_b_data (out_b_data),
    .count_a    (count_a),
    .count_b    (count_b)
  );

  // Advance the model by one clock using the inputs as they stand at the edge.
  task automatic tick();
    bit fire_m;
    bit acc_a;
    bit acc_b;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      fire_m = (qa.size() != 0) && (qb.size() != 0) && out_ready;
      acc_a  = in0_valid && (qa.size() < D);
      acc_b  = in1_valid && (qb.size() < D);
      if (fire_m) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (acc_a) qa.push_back(in0_data);
      if (acc_b) qb.push_back(in1_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
    in0_data = 16'h1111; in1_data = 32'h2222;
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (count_a !== 3'd0) $display("FAIL reset_count_a got %0d want 0", count_a); else n_pass++;
    n_checks++; if (count_b !== 3'd0) $display("FAIL reset_count_b got %0d want 0", count_b); else n_pass++;
    n_checks++; if (in0_ready !== 1'b1) $display("FAIL reset_in0_ready got %b want 1", in0_ready); else n_pass++;
    n_checks++; if (in1_ready !== 1'b1) $display("FAIL reset_in1_ready got %b want 1", in1_ready); else n_pass++;
    rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    n_checks++; if (out_a_data !== 16'h0) $display("FAIL reset_a_data got %h want 0", out_a_data); else n_pass++;
    n_checks++; if (out_b_data !== 32'h0) $display("FAIL reset_b_data got %h want 0", out_b_data); else n_pass++;
  endtask

  task automatic test_pairing();
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 16'd3;
    in1_valid = 1'b1; in1_data = 32'd5;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL pair_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_a_data !== 16'd3) $display("FAIL pair_a got %h want 3", out_a_data); else n_pass++;
    n_checks++; if (out_b_data !== 32'd5) $display("FAIL pair_b got %h want 5", out_b_data); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL pair_after_fire got %b want 0", out_valid); else n_pass++;
    n_checks++; if (count_a !== 3'd0) $display("FAIL pair_count_a got %0d want 0", count_a); else n_pass++;
  endtask

  task automatic test_skew();
    logic [WA-1:0] av [3];
    logic [WB-1:0] bv [3];
    av = '{16'hFFFF, 16'h7FFF, 16'h8000};
    bv = '{32'h1, 32'h0001_0000, 32'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0_valid = 1'b1; in0_data = av[i];
      tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL skew_no_b_valid[%0d] got %b want 0", i, out_valid); else n_pass++;
    end
    in0_valid = 1'b0;
    n_checks++; if (count_a !== 3'd3) $display("FAIL skew_count_a got %0d want 3", count_a); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      in1_valid = 1'b1; in1_data = bv[i];
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL skew_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (out_a_data !== av[i]) $display("FAIL skew_a[%0d] got %h want %h", i, out_a_data, av[i]); else n_pass++;
      n_checks++; if (out_b_data !== bv[i]) $display("FAIL skew_b[%0d] got %h want %h", i, out_b_data, bv[i]); else n_pass++;
    end
    in1_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL skew_drained got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in0_valid = 1'b1; in0_data = 16'h00A0 + 16'(i);
      in1_valid = 1'b1; in1_data = 32'h0B00 + 32'(i);
      tick();
    end
    n_checks++; if (count_a !== 3'd4 || count_b !== 3'd4) $display("FAIL full_counts got %0d/%0d want 4/4", count_a, count_b); else n_pass++;
    n_checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) $display("FAIL full_ready got %b/%b want 0/0", in0_ready, in1_ready); else n_pass++;
    in0_data = 16'hDEAD; in1_data = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (count_a !== 3'd4 || count_b !== 3'd4) $display("FAIL full_fifth_push got %0d/%0d want 4/4", count_a, count_b); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_a_data !== 16'h00A0 || out_b_data !== 32'h0B00)
      $display("FAIL full_hold got %b %h %h want 1 00a0 00000b00", out_valid, out_a_data, out_b_data); else n_pass++;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b1) $display("FAIL full_ready_back got %b/%b want 1/1", in0_ready, in1_ready); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_a_data !== 16'h00A0 + 16'(i) || out_b_data !== 32'h0B00 + 32'(i))
        $display("FAIL full_drain[%0d] got %b %h %h", i, out_valid, out_a_data, out_b_data);
      else n_pass++;
      tick();
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL full_empty got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [WA-1:0] pa [12];
    logic [WB-1:0] pb [12];
    for (int i = 0; i < 12; i++) begin
      pa[i] = 16'($urandom);
      pb[i] = $urandom;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in0_valid = 1'b1; in0_data = pa[i];
      in1_valid = 1'b1; in1_data = pb[i];
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in0_data = pa[c + 2]; in1_data = pb[c + 2];
      tick();
      n_checks++; if (count_a !== 3'd2 || count_b !== 3'd2) $display("FAIL wrap_count[%0d] got %0d/%0d want 2/2", c, count_a, count_b); else n_pass++;
      n_checks++;
      if (out_a_data !== pa[c + 1] || out_b_data !== pb[c + 1])
        $display("FAIL wrap_head[%0d] got %h %h want %h %h", c, out_a_data, out_b_data, pa[c + 1], pb[c + 1]);
      else n_pass++;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    n_checks++;
    if (out_a_data !== pa[11] || out_b_data !== pb[11])
      $display("FAIL wrap_tail got %h %h want %h %h", out_a_data, out_b_data, pa[11], pb[11]);
    else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL wrap_empty got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_midreset();
    logic [WA-1:0] na;
    logic [WB-1:0] nb;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in0_valid = 1'b1; in0_data = 16'($urandom);
      in1_valid = (i == 0); in1_data = $urandom;
      tick();
    end
    n_checks++; if (count_a !== 3'd3 || count_b !== 3'd1) $display("FAIL midrst_pre got %0d/%0d want 3/1", count_a, count_b); else n_pass++;
    rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count_a !== 3'd0 || count_b !== 3'd0) $display("FAIL midrst_counts got %0d/%0d want 0/0", count_a, count_b); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_a_data !== 16'h0 || out_b_data !== 32'h0) $display("FAIL midrst_data got %h %h want 0 0", out_a_data, out_b_data); else n_pass++;
    na = 16'($urandom); nb = $urandom;
    in0_valid = 1'b1; in0_data = na;
    in1_valid = 1'b1; in1_data = nb;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_a_data !== na || out_b_data !== nb)
      $display("FAIL midrst_first_pair got %b %h %h want 1 %h %h", out_valid, out_a_data, out_b_data, na, nb);
    else n_pass++;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit exp_valid;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in0_valid = $urandom_range(0, 1) == 1;
      in1_valid = $urandom_range(0, 2) != 0;
      in0_data  = 16'($urandom);
      in1_data  = $urandom;
      out_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      exp_valid = (qa.size() != 0) && (qb.size() != 0);
      n_checks++;
      if (out_valid !== exp_valid || int'(count_a) != qa.size() || int'(count_b) != qb.size())
        $display("FAIL rand_state[%0d] got v=%b %0d/%0d want v=%b %0d/%0d", c, out_valid, count_a, count_b,
                 exp_valid, qa.size(), qb.size());
      else n_pass++;
      n_checks++;
      if (in0_ready !== (rst || qa.size() < D) || in1_ready !== (rst || qb.size() < D))
        $display("FAIL rand_ready[%0d] got %b/%b want %b/%b", c, in0_ready, in1_ready,
                 rst || qa.size() < D, rst || qb.size() < D);
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (out_a_data !== qa[0] || out_b_data !== qb[0])
          $display("FAIL rand_pair[%0d] got %h %h want %h %h", c, out_a_data, out_b_data, qa[0], qb[0]);
        else n_pass++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    test_reset();
    test_pairing();
    test_skew();
    test_full();
    test_wrap();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_operand_join.md
PE_OPERAND_JOIN -- requirements
Module: pe_operand_join

Interface
REQ-001 Parameters SHALL be: WIDTH_A, default 16, width of operand A lane; WIDTH_B, default 32, width of operand B lane; DEPTH, default 4, entries per lane buffer (power of two, >= 2).
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be, in this order:
  - clk  input  1  clock, all state on rising edge
  - rst  input  1  synchronous active-high reset
  - in0_valid  input  1  lane A producer valid
  - in0_ready  output  1  lane A can accept
  - in0_data  input  WIDTH_A  lane A operand
  - in1_valid  input  1  lane B producer valid
  - in1_ready  output  1  lane B can accept
  - in1_data  input  WIDTH_B  lane B operand
  - out_valid  output  1  paired operands available
  - out_ready  input  1  downstream PE accepts pair
  - out_a_data  output  WIDTH_A  head of lane A
  - out_b_data  output  WIDTH_B  head of lane B
  - count_a  output  $clog2(DEPTH)+1  lane A occupancy
  - count_b  output  $clog2(DEPTH)+1  lane B occupancy

Function
REQ-004 Lane X SHALL accept a push when inX_valid && inX_ready on a rising edge; lanes are independent.
REQ-005 inX_ready SHALL be (count_X < DEPTH); there is no same-cycle pass-through when full, even if a pop occurs that cycle.
REQ-006 out_valid SHALL be (count_a != 0) && (count_b != 0), combinationally from registered counts.
REQ-007 A pop (fire) SHALL occur when out_valid && out_ready; it removes exactly one entry from each lane simultaneously.
REQ-008 out_a_data/out_b_data SHALL be the registered head entries of each lane; no combinational path from inX_data to out_*_data.
REQ-009 Latency SHALL be 1 cycle: data pushed at edge N is visible at the outputs after edge N when its lane was empty and the other lane is non-empty.
REQ-010 Push and pop on the same lane in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-011 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
REQ-012 Pairing SHALL be strictly FIFO-order: the k-th accepted A is paired with the k-th accepted B.
REQ-013 While out_valid && !out_ready, out_a_data, out_b_data and out_valid SHALL hold stable.
REQ-014 Data SHALL pass unmodified; no extension or truncation (width conversion is the downstream PE's job).

Reset
REQ-015 When rst is high at an edge, the block SHALL clear counts and pointers to 0 and all storage entries to 0, discarding in-flight entries regardless of handshakes that cycle.
REQ-016 After reset: out_valid=0, count_a=0, count_b=0, out_a_data=0, out_b_data=0, in0_ready=1, in1_ready=1.
REQ-017 inX_ready SHALL remain 1 during reset; pushes presented during a reset cycle are dropped.

Structure
REQ-018 A shared package SHALL hold the default width/depth localparams and a count-width helper function.
REQ-019 Each lane SHALL instantiate one sub-module, pe_lane_fifo (parameterised WIDTH, DEPTH; push/pop/count/head ports); pe_operand_join holds only the join logic.

Verification
REQ-020 The bench SHALL check the reset state: after rst is held 3 cycles -> out_valid=0, both counts 0, both readies 1.
REQ-021 Pairing: push A=3 and B=5 in the same cycle with out_ready=1 -> out_valid=1 one cycle later, out_a_data=3, out_b_data=32'd5, fire, then out_valid=0.
REQ-022 Skew: push A=16'hFFFF, 16'h7FFF, 16'h8000 on three cycles with no B, then push B=1, 32'h00010000, 0 -> count_a reaches 3 while out_valid=0; pairs emerge in order (FFFF,1), (7FFF,10000), (8000,0).
REQ-023 Backpressure/full: out_ready=0, push 4 A and 4 B -> counts=4, readies=0, a 5th push is ignored; raise out_ready -> 4 pairs drain in order, readies return to 1 after the first pop.
REQ-024 Simultaneous push/pop plus wrap: keep count_a=2 while pushing and popping each cycle for 10 cycles -> count stays 2, no value lost or duplicated across pointer wrap.
REQ-025 Mid-operation reset: with count_a=3, count_b=1, assert rst for one cycle -> next cycle counts 0, out_valid=0, out data 0; the first post-reset pair is (new A, new B).
